// File: rtl/orc_mem_port_arbiter.sv
// Shares one pipelined Wishbone slave between the ORC instruction-read,
// data-read and data-write masters, one transaction at a time.
module orc_mem_port_arbiter #(
  parameter int P_INST_STARVE_LIMIT = 4,
  parameter int P_TIMEOUT_CLKS      = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_sync_n,
  input  logic        i_inst_read_stb,
  output logic        o_inst_read_ack,
  input  logic [31:0] i_inst_read_addr,
  output logic [31:0] o_inst_read_data,
  input  logic        i_master_read_stb,
  output logic        o_master_read_ack,
  input  logic [31:0] i_master_read_addr,
  output logic [31:0] o_master_read_data,
  input  logic        i_master_write_stb,
  output logic        o_master_write_ack,
  input  logic [31:0] i_master_write_addr,
  input  logic [31:0] i_master_write_data,
  input  logic [3:0]  i_master_write_sel,
  output logic        o_slv_stb,
  output logic        o_slv_we,
  output logic [31:0] o_slv_addr,
  output logic [31:0] o_slv_wdata,
  output logic [3:0]  o_slv_sel,
  input  logic        i_slv_ack,
  input  logic [31:0] i_slv_rdata,
  output logic [2:0]  o_grant,
  output logic        o_timeout_err
);

  localparam int LP_SW = $clog2(P_INST_STARVE_LIMIT + 1);
  localparam int LP_TW =
    (P_TIMEOUT_CLKS > 0) ? $clog2(P_TIMEOUT_CLKS + 1) : 1;
  localparam logic [LP_SW-1:0] LP_LIMIT =
    LP_SW'(P_INST_STARVE_LIMIT);
  localparam logic [LP_TW-1:0] LP_TMO = LP_TW'(P_TIMEOUT_CLKS);
  localparam bit LP_TMO_EN = (P_TIMEOUT_CLKS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [LP_SW-1:0] r_starve;
  logic [LP_TW-1:0] r_tmo_cnt;

  logic        w_any;
  logic        w_inst_pri;
  logic        w_tmo;
  logic        w_done;
  logic [2:0]  w_win;
  logic [31:0] w_cap;

  assign w_any = i_inst_read_stb | i_master_read_stb |
                 i_master_write_stb;
  assign w_inst_pri = i_inst_read_stb && (r_starve == LP_LIMIT);
  assign w_tmo  = LP_TMO_EN && (r_tmo_cnt == LP_TMO);
  assign w_done = i_slv_ack || w_tmo;
  // An abort returns zero data rather than whatever floats on the bus.
  assign w_cap  = i_slv_ack ? i_slv_rdata : 32'h0;

  always_comb begin
    w_win = 3'b000;
    if (w_inst_pri)              w_win = 3'b001;
    else if (i_master_write_stb) w_win = 3'b100;
    else if (i_master_read_stb)  w_win = 3'b010;
    else if (i_inst_read_stb)    w_win = 3'b001;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_sync_n) begin
      r_state            <= S_IDLE;
      r_starve           <= '0;
      r_tmo_cnt          <= '0;
      o_slv_stb          <= 1'b0;
      o_slv_we           <= 1'b0;
      o_slv_addr         <= 32'h0;
      o_slv_wdata        <= 32'h0;
      o_slv_sel          <= 4'h0;
      o_grant            <= 3'b000;
      o_inst_read_ack    <= 1'b0;
      o_master_read_ack  <= 1'b0;
      o_master_write_ack <= 1'b0;
      o_timeout_err      <= 1'b0;
      o_inst_read_data   <= 32'h0;
      o_master_read_data <= 32'h0;
    end else begin
      o_inst_read_ack    <= 1'b0;
      o_master_read_ack  <= 1'b0;
      o_master_write_ack <= 1'b0;
      o_timeout_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_BUSY;
            o_grant   <= w_win;
            o_slv_stb <= 1'b1;
            r_tmo_cnt <= '0;
            if (w_win[2]) begin
              o_slv_we    <= 1'b1;
              o_slv_addr  <= i_master_write_addr;
              o_slv_wdata <= i_master_write_data;
              o_slv_sel   <= i_master_write_sel;
            end else begin
              o_slv_we    <= 1'b0;
              o_slv_addr  <= w_win[1] ? i_master_read_addr
                                      : i_inst_read_addr;
              o_slv_wdata <= 32'h0;
              o_slv_sel   <= 4'hF;
            end
            if (w_win[0] || !i_inst_read_stb)
              r_starve <= '0;
            else if (r_starve != LP_LIMIT)
              r_starve <= r_starve + 1'b1;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state            <= S_RESP;
            o_slv_stb          <= 1'b0;
            o_inst_read_ack    <= o_grant[0];
            o_master_read_ack  <= o_grant[1];
            o_master_write_ack <= o_grant[2];
            o_timeout_err      <= !i_slv_ack;
            if (o_grant[0]) o_inst_read_data   <= w_cap;
            if (o_grant[1]) o_master_read_data <= w_cap;
          end else if (LP_TMO_EN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          o_grant   <= 3'b000;
          r_tmo_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orc_mem_port_arbiter.sv
// Randomised and directed bench for orc_mem_port_arbiter against a
// behavioural memory scoreboard and a wait-state slave model.
module tb_orc_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        inst_stb, inst_ack;
  logic [31:0] inst_addr, inst_data;
  logic        rd_stb, rd_ack;
  logic [31:0] rd_addr, rd_data;
  logic        wr_stb, wr_ack;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_sel;
  logic        slv_stb, slv_we, slv_ack;
  logic [31:0] slv_addr, slv_wdata, slv_rdata;
  logic [3:0]  slv_sel;
  logic [2:0]  grant;
  logic        tmo_err;

  int errors = 0;
  int checks = 0;

  int s_waits = 0;
  bit s_mute  = 1'b0;
  int s_cnt   = 0;
  logic [31:0] smem  [0:255];
  logic [31:0] model [0:255];

  orc_mem_port_arbiter #(
    .P_INST_STARVE_LIMIT(LIMIT),
    .P_TIMEOUT_CLKS(TMO)
  ) dut (
    .i_clk(clk),
    .i_reset_sync_n(rst_n),
    .i_inst_read_stb(inst_stb),
    .o_inst_read_ack(inst_ack),
    .i_inst_read_addr(inst_addr),
    .o_inst_read_data(inst_data),
    .i_master_read_stb(rd_stb),
    .o_master_read_ack(rd_ack),
    .i_master_read_addr(rd_addr),
    .o_master_read_data(rd_data),
    .i_master_write_stb(wr_stb),
    .o_master_write_ack(wr_ack),
    .i_master_write_addr(wr_addr),
    .i_master_write_data(wr_data),
    .i_master_write_sel(wr_sel),
    .o_slv_stb(slv_stb),
    .o_slv_we(slv_we),
    .o_slv_addr(slv_addr),
    .o_slv_wdata(slv_wdata),
    .o_slv_sel(slv_sel),
    .i_slv_ack(slv_ack),
    .i_slv_rdata(slv_rdata),
    .o_grant(grant),
    .o_timeout_err(tmo_err)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hDEADBEEF ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  assign slv_ack   = slv_stb && !s_mute && (s_cnt == s_waits);
  assign slv_rdata = smem[slv_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      s_cnt <= 0;
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
    end else begin
      if (!slv_stb || slv_ack) s_cnt <= 0;
      else                     s_cnt <= s_cnt + 1;
      if (slv_stb && slv_ack && slv_we)
        smem[slv_addr[9:2]] <=
          (smem[slv_addr[9:2]] & ~bmask(slv_sel)) |
          (slv_wdata & bmask(slv_sel));
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    checks++;
    if ({slv_stb, slv_we, slv_addr, slv_wdata, slv_sel} !== '0) begin
      errors++;
      $display("FAIL reset_slv: got %h exp 0",
               {slv_stb, slv_we, slv_addr, slv_wdata, slv_sel});
    end
    checks++;
    if ({grant, inst_ack, rd_ack, wr_ack, tmo_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0",
               {grant, inst_ack, rd_ack, wr_ack, tmo_err});
    end
    checks++;
    if ({inst_data, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", {inst_data, rd_data});
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if ({slv_stb, grant} !== '0) begin
      errors++;
      $display("FAIL idle_no_req: got %b exp 0", {slv_stb, grant});
    end
  endtask

  task automatic test_single_inst;
    s_waits   = 0;
    inst_addr = 32'h0001_0000;
    inst_stb  = 1'b1;
    tick;
    checks++;
    if ({slv_stb, slv_we, slv_sel} !== 6'b10_1111 ||
        slv_addr !== 32'h0001_0000 || grant !== 3'b001) begin
      errors++;
      $display("FAIL inst_req: got stb%b we%b sel%h a%h g%b exp 1 0 f 10000 001",
               slv_stb, slv_we, slv_sel, slv_addr, grant);
    end
    checks++;
    if (inst_ack !== 1'b0) begin
      errors++;
      $display("FAIL inst_early_ack: got %b exp 0", inst_ack);
    end
    tick;
    checks++;
    if (inst_ack !== 1'b1 || inst_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL inst_ack: got ack%b d%h exp 1 deadbeef",
               inst_ack, inst_data);
    end
    checks++;
    if ({rd_ack, wr_ack, tmo_err} !== 3'b000) begin
      errors++;
      $display("FAIL inst_other_ack: got %b exp 000",
               {rd_ack, wr_ack, tmo_err});
    end
    inst_stb = 1'b0;
    tick;
    checks++;
    if (inst_ack !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL inst_ack_pulse: got ack%b g%b exp 0 000",
               inst_ack, grant);
    end
    tick;
    checks++;
    if (inst_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL inst_hold: got %h exp deadbeef", inst_data);
    end
  endtask

  task automatic test_write_then_read;
    logic [31:0] exp_d;
    s_waits = 1;
    wr_addr = 32'h40;
    wr_data = 32'hA5A5_1234;
    wr_sel  = 4'b1011;
    rd_addr = 32'h40;
    wr_stb  = 1'b1;
    rd_stb  = 1'b1;
    tick;
    checks++;
    if ({slv_stb, slv_we, slv_sel} !== 6'b11_1011 ||
        slv_addr !== 32'h40 || slv_wdata !== 32'hA5A5_1234 ||
        grant !== 3'b100) begin
      errors++;
      $display("FAIL wr_first: got stb%b we%b sel%h a%h d%h g%b exp write",
               slv_stb, slv_we, slv_sel, slv_addr, slv_wdata, grant);
    end
    tick;
    checks++;
    if (wr_ack !== 1'b0 || slv_stb !== 1'b1) begin
      errors++;
      $display("FAIL wr_wait: got ack%b stb%b exp 0 1", wr_ack, slv_stb);
    end
    tick;
    checks++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: got w%b r%b exp 1 0", wr_ack, rd_ack);
    end
    wr_stb = 1'b0;
    tick;
    checks++;
    if (slv_stb !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL gap_idle: got stb%b g%b exp 0 000", slv_stb, grant);
    end
    tick;
    checks++;
    if ({slv_stb, slv_we, slv_sel} !== 6'b10_1111 || grant !== 3'b010) begin
      errors++;
      $display("FAIL rd_next: got stb%b we%b sel%h g%b exp 1 0 f 010",
               slv_stb, slv_we, slv_sel, grant);
    end
    tick;
    tick;
    exp_d = (init_word(16) & ~bmask(4'b1011)) |
            (32'hA5A5_1234 & bmask(4'b1011));
    checks++;
    if (rd_ack !== 1'b1 || rd_data !== exp_d) begin
      errors++;
      $display("FAIL rd_data: got ack%b d%h exp 1 %h", rd_ack, rd_data, exp_d);
    end
    rd_stb = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    logic [2:0] exp_g [10];
    int  n;
    int  cyc;
    bit  prev;
    exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
              3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    n = 0; cyc = 0; prev = 1'b0;
    s_waits   = 0;
    inst_addr = 32'h80;
    wr_addr   = 32'h100;
    wr_data   = 32'h1357_9BDF;
    wr_sel    = 4'hF;
    inst_stb  = 1'b1;
    wr_stb    = 1'b1;
    while (n < 10 && cyc < 200) begin
      tick;
      cyc++;
      if (slv_stb && !prev) begin
        checks++;
        if (grant !== exp_g[n]) begin
          errors++;
          $display("FAIL starve_grant%0d: got %b exp %b", n, grant, exp_g[n]);
        end
        n++;
      end
      prev = slv_stb;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL starve_count: got %0d grants exp 10", n);
    end
    inst_stb = 1'b0;
    wr_stb   = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_timeout;
    int cyc;
    s_mute  = 1'b1;
    rd_addr = 32'h44;
    rd_stb  = 1'b1;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!slv_stb && cyc < 10);
    checks++;
    if (slv_stb !== 1'b1 || grant !== 3'b010) begin
      errors++;
      $display("FAIL tmo_start: got stb%b g%b exp 1 010", slv_stb, grant);
    end
    repeat (TMO) tick;
    checks++;
    if (rd_ack !== 1'b0 || slv_stb !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: got ack%b stb%b exp 0 1", rd_ack, slv_stb);
    end
    tick;
    checks++;
    if (rd_ack !== 1'b1 || tmo_err !== 1'b1 || rd_data !== 32'h0 ||
        slv_stb !== 1'b0) begin
      errors++;
      $display("FAIL tmo_ack: got ack%b err%b d%h stb%b exp 1 1 0 0",
               rd_ack, tmo_err, rd_data, slv_stb);
    end
    rd_stb = 1'b0;
    s_mute = 1'b0;
    tick;
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: got %b exp 0", tmo_err);
    end
    tick;
    rd_stb = 1'b1;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!rd_ack && cyc < 20);
    checks++;
    if (rd_ack !== 1'b1 || tmo_err !== 1'b0 || rd_data !== init_word(17)) begin
      errors++;
      $display("FAIL tmo_recover: got ack%b err%b d%h exp 1 0 %h",
               rd_ack, tmo_err, rd_data, init_word(17));
    end
    rd_stb = 1'b0;
    tick;
  endtask

  task automatic test_reset_busy;
    int cyc;
    int stray;
    s_mute  = 1'b1;
    rd_addr = 32'h48;
    rd_stb  = 1'b1;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!slv_stb && cyc < 10);
    tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({slv_stb, slv_we, slv_addr, slv_wdata, slv_sel, grant} !== '0) begin
      errors++;
      $display("FAIL rstb_slv: got %h exp 0",
               {slv_stb, slv_we, slv_addr, slv_wdata, slv_sel, grant});
    end
    checks++;
    if ({inst_ack, rd_ack, wr_ack, tmo_err, inst_data, rd_data} !== '0) begin
      errors++;
      $display("FAIL rstb_out: got %h exp 0",
               {inst_ack, rd_ack, wr_ack, tmo_err, inst_data, rd_data});
    end
    tick;
    s_mute = 1'b0;
    rst_n  = 1'b1;
    cyc = 0;
    stray = 0;
    do begin
      tick;
      cyc++;
      if (inst_ack || wr_ack) stray++;
    end while (!rd_ack && cyc < 20);
    checks++;
    if (rd_ack !== 1'b1 || rd_data !== init_word(18) || stray != 0) begin
      errors++;
      $display("FAIL rstb_rearb: got ack%b d%h stray%0d exp 1 %h 0",
               rd_ack, rd_data, stray, init_word(18));
    end
    rd_stb = 1'b0;
    tick;
  endtask

  task automatic test_random;
    bit          pend [3];
    int          issued;
    int          acked;
    bit          prev_stb;
    logic [68:0] snap;
    logic [68:0] prev_snap;
    logic [2:0]  acks;
    logic [68:0] exp_snap;
    int          idx;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = init_word(i);
    s_waits = 3;
    pend = '{1'b0, 1'b0, 1'b0};
    issued = 0; acked = 0;
    prev_stb = 1'b0;
    prev_snap = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick;
      acks = {wr_ack, rd_ack, inst_ack};
      if (acks != 3'b000) begin
        checks++;
        if ($countones(acks) != 1 || tmo_err !== 1'b0) begin
          errors++;
          $display("FAIL rnd_ack_shape: got %b err%b exp onehot 0",
                   acks, tmo_err);
        end
        if (inst_ack) begin
          checks++;
          if (!pend[0] || inst_data !== model[inst_addr[9:2]]) begin
            errors++;
            $display("FAIL rnd_inst: got pend%b d%h exp 1 %h",
                     pend[0], inst_data, model[inst_addr[9:2]]);
          end
          pend[0] = 1'b0; inst_stb = 1'b0; acked++;
        end
        if (rd_ack) begin
          checks++;
          if (!pend[1] || rd_data !== model[rd_addr[9:2]]) begin
            errors++;
            $display("FAIL rnd_read: got pend%b d%h exp 1 %h",
                     pend[1], rd_data, model[rd_addr[9:2]]);
          end
          pend[1] = 1'b0; rd_stb = 1'b0; acked++;
        end
        if (wr_ack) begin
          checks++;
          if (!pend[2]) begin
            errors++;
            $display("FAIL rnd_write: got unrequested ack exp none");
          end
          model[wr_addr[9:2]] = (model[wr_addr[9:2]] & ~bmask(wr_sel)) |
                                (wr_data & bmask(wr_sel));
          pend[2] = 1'b0; wr_stb = 1'b0; acked++;
        end
      end
      snap = {slv_we, slv_sel, slv_addr, slv_wdata};
      if (slv_stb && prev_stb) begin
        checks++;
        if (snap !== prev_snap) begin
          errors++;
          $display("FAIL rnd_stable: got %h exp %h", snap, prev_snap);
        end
      end
      if (slv_stb && !prev_stb) begin
        if (grant == 3'b100)
          exp_snap = {1'b1, wr_sel, wr_addr, wr_data};
        else if (grant == 3'b010)
          exp_snap = {1'b0, 4'hF, rd_addr, 32'h0};
        else
          exp_snap = {1'b0, 4'hF, inst_addr, 32'h0};
        checks++;
        if ($countones(grant) != 1 || snap !== exp_snap) begin
          errors++;
          $display("FAIL rnd_latch: got g%b %h exp %h", grant, snap, exp_snap);
        end
      end
      prev_stb  = slv_stb;
      prev_snap = snap;
      if (cyc < 1200) begin
        if (!pend[0] && $urandom_range(0, 2) == 0) begin
          idx = int'($urandom_range(0, 15));
          inst_addr = 32'(idx) << 2;
          inst_stb = 1'b1; pend[0] = 1'b1; issued++;
        end
        if (!pend[1] && $urandom_range(0, 2) == 0) begin
          idx = int'($urandom_range(0, 15));
          rd_addr = 32'(idx) << 2;
          rd_stb = 1'b1; pend[1] = 1'b1; issued++;
        end
        if (!pend[2] && $urandom_range(0, 2) == 0) begin
          idx = int'($urandom_range(0, 15));
          wr_addr = 32'(idx) << 2;
          wr_data = $urandom;
          wr_sel  = 4'($urandom_range(0, 15));
          wr_stb = 1'b1; pend[2] = 1'b1; issued++;
        end
      end else if (!pend[0] && !pend[1] && !pend[2]) begin
        break;
      end
    end
    checks++;
    if (issued != acked || pend[0] || pend[1] || pend[2]) begin
      errors++;
      $display("FAIL rnd_complete: got acked %0d exp %0d", acked, issued);
    end
    inst_stb = 1'b0;
    rd_stb   = 1'b0;
    wr_stb   = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    inst_stb  = 1'b0;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    inst_addr = 32'h0;
    rd_addr   = 32'h0;
    wr_addr   = 32'h0;
    wr_data   = 32'h0;
    wr_sel    = 4'h0;
    test_reset;
    test_single_inst;
    test_write_then_read;
    test_starvation;
    test_timeout;
    test_reset_busy;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
